// File: rtl/timer_unit_if.sv
// Register bus between the CPU and a timer_unit instance.
// Same address/data/strobe layout as the output_compare bus.
interface timer_unit_if;
  logic [12:0] addr_i;
  logic [31:0] data_i;
  logic        en_i;
  logic [3:0]  we_i;
  logic [31:0] data_o;

  modport master (
    output addr_i,
    output data_i,
    output en_i,
    output we_i,
    input  data_o
  );

  modport slave (
    input  addr_i,
    input  data_i,
    input  en_i,
    input  we_i,
    output data_o
  );
endinterface

// File: rtl/timer_unit.sv
// Prescaled up-counter with programmable period, sticky overflow and irq.
// tm_o / tm_of_o feed an output_compare timer input.
module timer_unit #(
  parameter int WIDTH   = 32,
  parameter int PRESC_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  timer_unit_if.slave      bus,
  output logic [WIDTH-1:0] tm_o,
  output logic             tm_of_o,
  output logic             irq_o
);

  localparam logic [12:0] A_CONF  = 13'h000;
  localparam logic [12:0] A_COUNT = 13'h004;
  localparam logic [12:0] A_PER   = 13'h008;
  localparam logic [12:0] A_PRESC = 13'h00C;
  localparam logic [12:0] A_STAT  = 13'h010;

  logic               wr;
  logic               rd;
  logic               a_conf;
  logic               a_count;
  logic               a_per;
  logic               a_presc;
  logic               a_stat;
  logic               w_conf;
  logic               w_count;
  logic               w_per;
  logic               w_presc;
  logic               w_clr;
  logic               tick;
  logic               wrap;
  logic               cf_en;
  logic               cf_os;
  logic               cf_ie;
  logic               ovf;
  logic               of_q;
  logic [WIDTH-1:0]   count;
  logic [WIDTH-1:0]   period;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] pcnt;
  logic [31:0]        rdata;

  function automatic logic [31:0] lanes(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  assign wr      = bus.en_i && (|bus.we_i);
  assign rd      = bus.en_i && (bus.we_i == 4'b0000);
  assign a_conf  = (bus.addr_i == A_CONF);
  assign a_count = (bus.addr_i == A_COUNT);
  assign a_per   = (bus.addr_i == A_PER);
  assign a_presc = (bus.addr_i == A_PRESC);
  assign a_stat  = (bus.addr_i == A_STAT);
  assign w_conf  = wr && a_conf && bus.we_i[0];
  assign w_count = wr && a_count;
  assign w_per   = wr && a_per;
  assign w_presc = wr && a_presc;
  assign w_clr   = wr && a_stat && bus.we_i[0] && bus.data_i[0];

  // A bus write to COUNT suppresses both increment and wrap.
  assign tick = cf_en && (pcnt == presc);
  assign wrap = tick && !w_count && (count >= period);

  assign tm_o    = count;
  assign tm_of_o = of_q;
  assign irq_o   = ovf & cf_ie;

  // Read mux over the current register values.
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      a_conf:  rdata = {29'b0, cf_ie, cf_os, cf_en};
      a_count: rdata = 32'(count);
      a_per:   rdata = 32'(period);
      a_presc: rdata = 32'(presc);
      a_stat:  rdata = {31'b0, ovf};
      default: rdata = '0;
    endcase
  end

  // Prescaler: restarts on PRESC write, while disabled, and on each tick.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcnt <= '0;
    end else if (w_presc || !cf_en || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // Counter and overflow pulse, registered together so of shows with 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
      of_q  <= 1'b0;
    end else begin
      of_q <= wrap;
      if (w_count)
        count <= WIDTH'(lanes(32'(count), bus.data_i, bus.we_i));
      else if (wrap)
        count <= '0;
      else if (tick)
        count <= count + 1'b1;
    end
  end

  // CONF: explicit EN write wins over the one-shot auto-disable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cf_en <= 1'b0;
      cf_os <= 1'b0;
      cf_ie <= 1'b0;
    end else if (w_conf) begin
      cf_en <= bus.data_i[0];
      cf_os <= bus.data_i[1];
      cf_ie <= bus.data_i[2];
    end else if (wrap && cf_os) begin
      cf_en <= 1'b0;
    end
  end

  // PERIOD and PRESC with per-byte enables.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      period <= '0;
      presc  <= '0;
    end else begin
      if (w_per)
        period <= WIDTH'(lanes(32'(period), bus.data_i, bus.we_i));
      if (w_presc)
        presc <= PRESC_W'(lanes(32'(presc), bus.data_i, bus.we_i));
    end
  end

  // Sticky overflow: a wrap in the same cycle beats the W1C clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf <= 1'b0;
    end else if (wrap) begin
      ovf <= 1'b1;
    end else if (w_clr) begin
      ovf <= 1'b0;
    end
  end

  // Registered read data, held when no read is issued.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.data_o <= '0;
    end else if (rd) begin
      bus.data_o <= rdata;
    end
  end

endmodule

// File: tb/tb_timer_unit.sv
// Scoreboard bench for timer_unit: driver pushes model expectations,
// monitor pops and compares one entry per clock after the edge.
module tb_timer_unit;

  logic        clk;
  logic        rst_ni;
  logic [31:0] tm;
  logic        tm_of;
  logic        irq;

  timer_unit_if bus ();

  timer_unit #(
    .WIDTH   (32),
    .PRESC_W (16)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .bus     (bus),
    .tm_o    (tm),
    .tm_of_o (tm_of),
    .irq_o   (irq)
  );

  typedef struct {
    logic [31:0] tm;
    logic        of;
    logic        irq;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  logic        m_en, m_os, m_ie, m_ovf, m_of;
  logic [31:0] m_cnt, m_per, m_rd;
  logic [15:0] m_presc, m_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] lanes(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] reg_read(input logic [12:0] a);
    case (a)
      13'h000: return {29'b0, m_ie, m_os, m_en};
      13'h004: return m_cnt;
      13'h008: return m_per;
      13'h00C: return {16'b0, m_presc};
      13'h010: return {31'b0, m_ovf};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_en = 0; m_os = 0; m_ie = 0; m_ovf = 0; m_of = 0;
    m_cnt = 0; m_per = 0; m_rd = 0; m_presc = 0; m_pc = 0;
  endtask

  task automatic model_step(
    input logic [12:0] a,
    input logic [31:0] d,
    input logic        e,
    input logic [3:0]  w
  );
    logic        wr, rd, tick, wrap;
    logic [31:0] t;
    wr   = e && (w != 4'b0);
    rd   = e && (w == 4'b0);
    tick = m_en && (m_pc == m_presc);
    wrap = 1'b0;
    if (rd) m_rd = reg_read(a);
    if ((wr && a == 13'h00C) || !m_en || tick) m_pc = 0;
    else m_pc = m_pc + 1;
    if (wr && a == 13'h004) begin
      m_cnt = lanes(m_cnt, d, w);
    end else if (tick) begin
      if (m_cnt >= m_per) begin
        m_cnt = 0;
        wrap  = 1'b1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    if (wrap && m_os) m_en = 1'b0;
    if (wr && a == 13'h000 && w[0]) begin
      m_en = d[0]; m_os = d[1]; m_ie = d[2];
    end
    if (wr && a == 13'h008) m_per = lanes(m_per, d, w);
    if (wr && a == 13'h00C) begin
      t = lanes({16'b0, m_presc}, d, w);
      m_presc = t[15:0];
    end
    if (wr && a == 13'h010 && w[0] && d[0]) m_ovf = 1'b0;
    if (wrap) m_ovf = 1'b1;
    m_of = wrap;
  endtask

  task automatic drive(
    input logic [12:0] a,
    input logic [31:0] d,
    input logic        e,
    input logic [3:0]  w
  );
    exp_t x;
    @(negedge clk);
    bus.addr_i = a;
    bus.data_i = d;
    bus.en_i   = e;
    bus.we_i   = w;
    model_step(a, d, e, w);
    x.tm  = m_cnt;
    x.of  = m_of;
    x.irq = m_ovf & m_ie;
    x.rd  = m_rd;
    sb.push_back(x);
  endtask

  task automatic wr_reg(input logic [12:0] a, input logic [31:0] d);
    drive(a, d, 1'b1, 4'hF);
  endtask

  task automatic rd_reg(input logic [12:0] a);
    drive(a, 32'h0, 1'b1, 4'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(13'h0, 32'h0, 1'b0, 4'h0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Monitor: one expectation per clock, sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (tm !== e.tm || tm_of !== e.of || irq !== e.irq || bus.data_o !== e.rd) begin
          n_err++;
          $display("FAIL cycle%0d outputs: tm=%h of=%b irq=%b rd=%h want tm=%h of=%b irq=%b rd=%h",
                   cyc, tm, tm_of, irq, bus.data_o, e.tm, e.of, e.irq, e.rd);
        end
      end
    end
  end

  initial begin
    logic [12:0] a;
    logic [31:0] d;
    logic [3:0]  w;
    int          k;
    int          r;

    bus.addr_i = '0;
    bus.data_i = '0;
    bus.en_i   = 1'b0;
    bus.we_i   = '0;
    rst_ni     = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_tm", tm, 32'h0);
    chk("reset_of", {31'b0, tm_of}, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    chk("reset_rd", bus.data_o, 32'h0);
    rst_ni = 1'b1;

    wr_reg(13'h00C, 0);
    wr_reg(13'h008, 3);
    wr_reg(13'h000, 1);
    idle(12);
    rd_reg(13'h004);

    wr_reg(13'h000, 0);
    wr_reg(13'h00C, 2);
    wr_reg(13'h008, 1);
    wr_reg(13'h004, 0);
    wr_reg(13'h000, 1);
    idle(15);

    wr_reg(13'h000, 0);
    wr_reg(13'h010, 1);
    wr_reg(13'h00C, 0);
    wr_reg(13'h008, 2);
    wr_reg(13'h004, 0);
    wr_reg(13'h000, 7);
    idle(8);
    rd_reg(13'h000);
    rd_reg(13'h010);
    wr_reg(13'h010, 1);
    idle(2);

    wr_reg(13'h000, 0);
    wr_reg(13'h008, 0);
    wr_reg(13'h004, 0);
    wr_reg(13'h000, 5);
    idle(2);
    wr_reg(13'h010, 1);
    rd_reg(13'h010);
    wr_reg(13'h000, 4);
    wr_reg(13'h010, 1);
    idle(1);

    wr_reg(13'h008, 4);
    wr_reg(13'h004, 0);
    wr_reg(13'h000, 1);
    idle(2);
    wr_reg(13'h004, 32'h10);
    idle(3);
    wr_reg(13'h008, 0);
    drive(13'h008, 32'h123456AB, 1'b1, 4'b0001);
    rd_reg(13'h008);
    idle(1);

    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      k = $urandom_range(0, 6);
      if (k <= 4) a = 13'(k * 4);
      else if (k == 5) a = 13'($urandom);
      else a = 13'h014;
      if (r <= 5) begin
        idle(1);
      end else if (r <= 7) begin
        rd_reg(a);
      end else begin
        w = ($urandom_range(0, 9) < 7) ? 4'hF : 4'($urandom);
        if (w == 4'h0) w = 4'h1;
        d = $urandom;
        if (a == 13'h000) d[0] = ($urandom_range(0, 3) != 0);
        else if (a == 13'h004 || a == 13'h008)
          d = ($urandom_range(0, 9) < 9) ? 32'($urandom_range(0, 9)) : d;
        else if (a == 13'h00C) d = 32'($urandom_range(0, 3));
        drive(a, d, 1'b1, w);
      end
    end

    wr_reg(13'h000, 0);
    wr_reg(13'h00C, 0);
    wr_reg(13'h008, 0);
    wr_reg(13'h000, 5);
    idle(2);
    wr_reg(13'h000, 4);
    wr_reg(13'h008, 100);
    wr_reg(13'h004, 5);
    rd_reg(13'h004);
    idle(1);

    @(negedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_tm", tm, 32'h0);
    chk("async_rst_rd", bus.data_o, 32'h0);
    chk("async_rst_irq", {31'b0, irq}, 32'h0);
    chk("async_rst_of", {31'b0, tm_of}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;
    rd_reg(13'h004);
    rd_reg(13'h000);
    idle(2);

    @(posedge clk);
    #2;
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
